// File: rtl/mips16_pkg.sv
// Shared types and widths for the mips16 data-memory path: arbiter states,
// memory owner encoding and a saturating counter helper.
package mips16_pkg;

  localparam int DMEM_ADDR_W = 4;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    CPU_PRI   = 2'd0,
    HOST_PRI  = 2'd1,
    HOST_LOCK = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Arbitration FSM for the shared data memory: priority state, host starvation
// counter and the combinational owner decode for the current cycle.
module dmem_arb_fsm
  import mips16_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  logic   dbg_lock,
  output owner_t owner
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_t state_reg;
  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;
  logic       host_gnt;

  always_comb begin
    owner = OWN_NONE;
    case (state_reg)
      CPU_PRI: begin
        if (cpu_req)      owner = OWN_CPU;
        else if (dbg_req) owner = OWN_HOST;
      end
      HOST_PRI: begin
        if (dbg_req)      owner = OWN_HOST;
        else if (cpu_req) owner = OWN_CPU;
      end
      // CPU never gets in while the host holds the lock, even on idle host cycles.
      HOST_LOCK: begin
        if (dbg_req)      owner = OWN_HOST;
      end
      default: owner = OWN_NONE;
    endcase
  end

  assign host_gnt = (owner == OWN_HOST);

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!dbg_req || host_gnt)
      wait_cnt_next = 4'd0;
    else if (wait_cnt_reg < MAX_WAIT_C)
      wait_cnt_next = wait_cnt_reg + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= CPU_PRI;
      wait_cnt_reg <= 4'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      case (state_reg)
        CPU_PRI: begin
          if (host_gnt)
            state_reg <= dbg_lock ? HOST_LOCK : CPU_PRI;
          else if (dbg_req && wait_cnt_next >= MAX_WAIT_C)
            state_reg <= HOST_PRI;
        end
        HOST_PRI: begin
          if (host_gnt)
            state_reg <= dbg_lock ? HOST_LOCK : CPU_PRI;
        end
        HOST_LOCK: begin
          if (!dbg_req || !dbg_lock)
            state_reg <= CPU_PRI;
        end
        default: state_reg <= CPU_PRI;
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU and a debug/loader host.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
  parameter int ADDR_W   = mips16_pkg::DMEM_ADDR_W,
  parameter int DATA_W   = mips16_pkg::DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [7:0]        conflict_cnt,
  output logic [7:0]        stall_cnt
`endif
);

  import mips16_pkg::*;

  owner_t owner;

  dmem_arb_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .dbg_lock (dbg_lock),
    .owner    (owner)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_re    = ~cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_HOST: begin
        mem_we    = dbg_we;
        mem_re    = ~dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = (owner == OWN_CPU) ? mem_rdata : '0;
  assign cpu_stall = cpu_req & (owner != OWN_CPU);
  assign dbg_gnt   = (owner == OWN_HOST);

  // Read data is captured at the grant edge, so the host sees it one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we)
        dbg_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 8'd0;
      stall_cnt    <= 8'd0;
    end else begin
      if (cpu_req && dbg_req)
        conflict_cnt <= sat_inc8(conflict_cnt);
      if (cpu_stall)
        stall_cnt <= sat_inc8(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural data memory.
module tb_dmem_port_arbiter;
  import mips16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;
  logic        dbg_gnt, dbg_rvalid;
  logic        mem_we, mem_re;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [7:0]  conflict_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Data memory stand-in: combinational read, synchronous write, preloaded on reset.
  logic [15:0] mem [16];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 2) ? 16'h9ABC : 16'h0000;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c_req, input logic c_we, input logic [3:0] c_addr,
                       input logic [15:0] c_wd, input logic d_req, input logic d_we,
                       input logic d_lock, input logic [3:0] d_addr, input logic [15:0] d_wd);
    @(negedge clk);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_lock = d_lock; dbg_addr = d_addr; dbg_wdata = d_wd;
    #2;
    $display("t=%0t cpu_req=%b dbg_req=%b lock=%b stall=%b gnt=%b mem_addr=%h",
             $time, cpu_req, dbg_req, dbg_lock, cpu_stall, dbg_gnt, mem_addr);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0;
    after_edge();
    after_edge();
    // 1. reset state
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rst_rdata", 32'(dbg_rdata), 32'd0);
    check("rst_state", 32'(dut.u_fsm.state_reg), 32'(CPU_PRI));
    @(negedge clk); rst = 1'b0;

    // 2. CPU read of address 2 alone
    drive(1, 0, 4'd2, 16'h0, 0, 0, 0, 4'd0, 16'h0);
    check("cpu_rd_data", 32'(cpu_rdata), 32'h9ABC);
    check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    check("cpu_rd_gnt", 32'(dbg_gnt), 32'd0);
    check("cpu_rd_re", 32'(mem_re), 32'd1);

    // 3. host write BEEF @5 then host read @5
    drive(0, 0, 4'd0, 16'h0, 1, 1, 0, 4'd5, 16'hBEEF);
    check("hw_gnt", 32'(dbg_gnt), 32'd1);
    check("hw_we", 32'(mem_we), 32'd1);
    check("hw_addr", 32'(mem_addr), 32'd5);
    drive(0, 0, 4'd0, 16'h0, 1, 0, 0, 4'd5, 16'h0);
    check("hr_gnt", 32'(dbg_gnt), 32'd1);
    check("hw_no_rvalid", 32'(dbg_rvalid), 32'd0);
    after_edge();
    check("hr_rvalid", 32'(dbg_rvalid), 32'd1);
    check("hr_rdata", 32'(dbg_rdata), 32'hBEEF);
    drive(0, 0, 4'd0, 16'h0, 0, 0, 0, 4'd0, 16'h0);
    after_edge();
    check("hr_rvalid_pulse", 32'(dbg_rvalid), 32'd0);

    // 4. continuous conflict: CPU cycles 0-2, host cycle 3, CPU cycle 4
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4'd1, 16'h0, 1, 0, 0, 4'd2, 16'h0);
      check($sformatf("starve_stall_%0d", i), 32'(cpu_stall), (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("starve_gnt_%0d", i), 32'(dbg_gnt), (i == 3) ? 32'd1 : 32'd0);
      if (i == 4) begin
        check("starve_rvalid", 32'(dbg_rvalid), 32'd1);
        check("starve_rdata", 32'(dbg_rdata), 32'h9ABC);
      end
    end
    drive(0, 0, 4'd0, 16'h0, 0, 0, 0, 4'd0, 16'h0);

    // 5. starve to HOST_PRI, then locked burst of writes @8..10 against a busy CPU
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'd1, 16'h0, 1, 1, 1, 4'd8, 16'h1111);
      check($sformatf("pre_lock_gnt_%0d", i), 32'(dbg_gnt), 32'd0);
    end
    drive(1, 0, 4'd1, 16'h0, 1, 1, 1, 4'd8, 16'h1111);
    check("lock0_stall", 32'(cpu_stall), 32'd1);
    check("lock0_gnt", 32'(dbg_gnt), 32'd1);
    drive(1, 0, 4'd1, 16'h0, 1, 1, 1, 4'd9, 16'h2222);
    check("lock1_stall", 32'(cpu_stall), 32'd1);
    check("lock1_gnt", 32'(dbg_gnt), 32'd1);
    drive(1, 0, 4'd1, 16'h0, 1, 1, 0, 4'd10, 16'h3333);
    check("lock2_stall", 32'(cpu_stall), 32'd1);
    check("lock2_addr", 32'(mem_addr), 32'd10);
    after_edge();
    check("lock_exit_state", 32'(dut.u_fsm.state_reg), 32'(CPU_PRI));
    drive(1, 0, 4'd9, 16'h0, 1, 0, 0, 4'd3, 16'h0);
    check("post_lock_stall", 32'(cpu_stall), 32'd0);
    check("post_lock_rd9", 32'(cpu_rdata), 32'h2222);
    drive(1, 0, 4'd10, 16'h0, 0, 0, 0, 4'd0, 16'h0);
    check("post_lock_rd10", 32'(cpu_rdata), 32'h3333);

    // 6. reset while locked with a read granted
    drive(0, 0, 4'd0, 16'h0, 1, 0, 1, 4'd8, 16'h0);
    check("lock_enter_gnt", 32'(dbg_gnt), 32'd1);
    drive(1, 0, 4'd0, 16'h0, 1, 0, 1, 4'd8, 16'h0);
    check("lock_cpu_stall", 32'(cpu_stall), 32'd1);
    rst = 1'b1;
    after_edge();
    check("rst_lock_state", 32'(dut.u_fsm.state_reg), 32'(CPU_PRI));
    check("rst_lock_rvalid", 32'(dbg_rvalid), 32'd0);
    @(negedge clk); rst = 1'b0;
    #2;
    check("rst_lock_stall", 32'(cpu_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
